// File: rtl/fp16_pkg.sv
// fp16_pkg: shared FP16 constants, FSM state type, adder and post-stage helpers
package fp16_pkg;
  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam int FP16_EXP_MSB = 14;
  localparam int FP16_EXP_LSB = 10;
  localparam logic [4:0] FP16_EXP_MAX = 5'd31;

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} red_state_t;

  // Divide by 2^k via exponent: Inf/NaN pass, underflow flushes to signed zero.
  function automatic logic [15:0] fp16_exp_sub(input logic [15:0] v, input int k);
    logic [4:0] e;
    e = v[FP16_EXP_MSB:FP16_EXP_LSB];
    return (e == FP16_EXP_MAX) ? v : (int'(e) <= k) ? {v[15], 15'b0} : {v[15], e - 5'(k), v[9:0]};
  endfunction

  // IEEE binary16 add, round-to-nearest-even, subnormals supported.
  function automatic logic [15:0] fp16_add(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] a, b;
    logic [5:0] ea, eb, e, sft, lz, d;
    logic [13:0] sa, sb, n;
    logic [27:0] sh;
    logic [14:0] r, pk;
    logic inc;
    a = (x[14:0] >= y[14:0]) ? x : y;
    b = (x[14:0] >= y[14:0]) ? y : x;
    ea = (a[14:10] == 5'd0) ? 6'd1 : {1'b0, a[14:10]};
    eb = (b[14:10] == 5'd0) ? 6'd1 : {1'b0, b[14:10]};
    d = ea - eb;
    sa = {a[14:10] != 5'd0, a[9:0], 3'b0};
    // Aligned smaller operand keeps a sticky bit for everything shifted out.
    sh = {b[14:10] != 5'd0, b[9:0], 3'b0, 14'b0} >> ((d > 6'd27) ? 6'd27 : d);
    sb = sh[27:14] | {13'b0, |sh[13:0]};
    r = (a[15] == b[15]) ? {1'b0, sa} + {1'b0, sb} : {1'b0, sa} - {1'b0, sb};
    lz = 6'd14;
    for (int i = 0; i < 14; i++) if (r[i]) lz = 6'(13 - i);
    if (r[14]) begin
      n = {r[14:2], r[1] | r[0]};
      e = ea + 6'd1;
    end else begin
      // Normalise left but never below exponent 1; what stays unnormalised is subnormal.
      sft = (lz < ea - 6'd1) ? lz : ea - 6'd1;
      n = r[13:0] << sft;
      e = n[13] ? ea - sft : 6'd0;
    end
    inc = n[2] & (n[1] | n[0] | n[3]);
    pk = {e[4:0], n[12:3]} + {14'b0, inc};
    if ((x[14:10] == FP16_EXP_MAX && x[9:0] != 10'd0) || (y[14:10] == FP16_EXP_MAX && y[9:0] != 10'd0) ||
        (x[14:0] == 15'h7C00 && y[14:0] == 15'h7C00 && x[15] != y[15])) return 16'h7E00;
    if (a[14:10] == FP16_EXP_MAX) return a;
    if (r == 15'd0) return {a[15] & b[15], 15'b0};
    if (e >= 6'd31) return {a[15], 15'h7C00};
    return {a[15], pk};
  endfunction
endpackage

// File: rtl/fp16_tile_reducer_if.sv
// fp16_tile_reducer_if: run control, operand bus and result stream of the tile reducer
// master = requester (drives start/mean_mode/hC_flat), slave = reducer
interface fp16_tile_reducer_if #(parameter int T = 16, parameter int N = 32, parameter int DW = 16);
  logic start;
  logic mean_mode;
  logic [T*N*DW-1:0] hC_flat;
  logic busy;
  logic out_valid;
  logic [DW-1:0] out_data;
  logic [$clog2(T):0] out_index;
  logic [T*DW-1:0] sum_flat;
  logic done;
  modport master(output start, mean_mode, hC_flat, input busy, out_valid, out_data, out_index, sum_flat, done);
  modport slave(input start, mean_mode, hC_flat, output busy, out_valid, out_data, out_index, sum_flat, done);
endinterface

// File: rtl/fp16_add_wrapper.sv
// fp16_add_wrapper: FP16 adder with LAT-cycle latency; only the valid path is reset
// ports: clk, rst_n, valid_in, a, b -> sum, valid_out (LAT cycles later)
module fp16_add_wrapper import fp16_pkg::*; #(parameter int LAT = 11) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        valid_out
);
  logic [15:0] d [LAT];
  logic [LAT-1:0] v;
  always_ff @(posedge clk) begin
    d[0] <= fp16_add(a, b);
    for (int i = 1; i < LAT; i++) d[i] <= d[i-1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) v <= '0;
    else v <= LAT'({v, valid_in});
  assign sum = d[LAT-1];
  assign valid_out = v[LAT-1];
endmodule

// File: rtl/fp16_adder_tree_gen.sv
// fp16_adder_tree_gen: pipelined binary FP16 adder tree over N_PAD lanes, log2(N_PAD) levels
// ports: clk, rst_n, valid_in, in_flat (lane i at [16*i +: 16]) -> sum, valid_out
module fp16_adder_tree_gen #(parameter int N_PAD = 32, parameter int ADD_LAT = 11) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic [N_PAD*16-1:0]  in_flat,
  output logic [15:0]          sum,
  output logic                 valid_out
);
  localparam int L = $clog2(N_PAD);
  genvar l, j;
  for (l = 0; l < L; l++) begin : lv
    localparam int W = N_PAD >> (l + 1);
    logic [W*16-1:0] d;
    logic [W-1:0] v;
    logic [2*W*16-1:0] src;
    logic src_v;
    if (l == 0) begin : s0
      assign src = in_flat;
      assign src_v = valid_in;
    end else begin : sn
      assign src = lv[l-1].d;
      assign src_v = &lv[l-1].v;
    end
    for (j = 0; j < W; j++) begin : add
      fp16_add_wrapper #(.LAT(ADD_LAT)) u_add (
        .clk(clk), .rst_n(rst_n), .valid_in(src_v),
        .a(src[2*j*16 +: 16]), .b(src[(2*j+1)*16 +: 16]),
        .sum(d[j*16 +: 16]), .valid_out(v[j])
      );
    end
  end
  assign sum = lv[L-1].d;
  assign valid_out = &lv[L-1].v;
endmodule

// File: rtl/fp16_tile_reducer.sv
// fp16_tile_reducer: reduces T=B*H*P tiles of N FP16 values to one sum (or mean) each
// ports: clk, rst_n (async, active low), bus (slave): start/mean_mode/hC_flat in; busy, out_valid/out_data/out_index stream, sum_flat, done out
module fp16_tile_reducer import fp16_pkg::*; #(
  parameter int B = 1,
  parameter int H = 4,
  parameter int P = 4,
  parameter int N = 32,
  parameter int DW = 16,
  parameter int ADD_LAT = 11
) (
  input logic clk,
  input logic rst_n,
  fp16_tile_reducer_if.slave bus
);
  localparam int T = B * H * P;
  localparam int DEPTH = $clog2(N);
  localparam int N_PAD = 1 << DEPTH;
  localparam bit N_POW2 = (N == N_PAD);
  localparam int IW = $clog2(T) + 1;
  red_state_t st;
  logic mode_q;
  logic [IW-1:0] in_idx, res_cnt;
  logic [N_PAD*16-1:0] lanes;
  logic [15:0] tsum, post;
  logic tvalid;
  // Lanes beyond N carry +0 so the padded tree sums exactly the N real elements.
  always_comb begin
    lanes = {N_PAD{FP16_ZERO}};
    lanes[N*16-1:0] = bus.hC_flat[in_idx*N*DW +: N*DW];
  end
  fp16_adder_tree_gen #(.N_PAD(N_PAD), .ADD_LAT(ADD_LAT)) u_tree (
    .clk(clk), .rst_n(rst_n), .valid_in(st == S_FEED), .in_flat(lanes), .sum(tsum), .valid_out(tvalid)
  );
  // Mean is only exact as an exponent shift when N is a power of two.
  assign post = (mode_q && N_POW2) ? fp16_exp_sub(tsum, DEPTH) : tsum;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= S_IDLE;
      mode_q <= 1'b0;
      in_idx <= '0;
      res_cnt <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_index <= '0;
      bus.sum_flat <= '0;
    end else begin
      bus.done <= 1'b0;
      bus.out_valid <= tvalid;
      if (tvalid) begin
        bus.out_data <= post;
        bus.out_index <= res_cnt;
        res_cnt <= res_cnt + 1'b1;
      end
      if (bus.out_valid) bus.sum_flat[bus.out_index*DW +: DW] <= bus.out_data;
      case (st)
        S_IDLE: if (bus.start) begin
          st <= S_FEED;
          mode_q <= bus.mean_mode;
          in_idx <= '0;
          res_cnt <= '0;
          bus.busy <= 1'b1;
        end
        S_FEED: if (in_idx == IW'(T - 1)) st <= S_DRAIN;
                else in_idx <= in_idx + 1'b1;
        S_DRAIN: if (bus.out_valid && bus.out_index == IW'(T - 1)) begin
          st <= S_DONE;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
        end
        default: st <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_fp16_tile_reducer.sv
// tb_fp16_tile_reducer: directed vector table plus reset/restart/non-power-of-two sequences
module tb_fp16_tile_reducer;
  localparam int T = 16, N = 32, LAT = 11, PL = LAT * 5 + 1;
  localparam int T5 = 4, N5 = 5, PL5 = LAT * 3 + 1;
  typedef struct {
    logic [95:0] name;
    logic mode;
    logic single;
    logic [15:0] ev, od, xev, xod;
    int restart;
  } vec_t;
  logic clk = 0, rst_n = 0;
  int n_vec = 0, n_chk = 0, n_err = 0;
  vec_t vt [8];
  always #5 clk = ~clk;
  fp16_tile_reducer_if #(.T(T), .N(N), .DW(16)) bus();
  fp16_tile_reducer_if #(.T(T5), .N(N5), .DW(16)) bus5();
  fp16_tile_reducer #(.B(1), .H(4), .P(4), .N(N), .DW(16), .ADD_LAT(LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  fp16_tile_reducer #(.B(1), .H(2), .P(2), .N(N5), .DW(16), .ADD_LAT(LAT)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int first, nval, dcyc, ndone;
    logic [15:0] x;
    first = -1; nval = 0; dcyc = -1; ndone = 0;
    n_vec++;
    for (int g = 0; g < T * N; g++)
      bus.hC_flat[g*16 +: 16] = (v.single && g % N != 0) ? 16'h0000 : (((g / N) % 2 == 0) ? v.ev : v.od);
    bus.mean_mode = v.mode;
    @(negedge clk) bus.start = 1;
    for (int c = 1; c <= PL + T + 8; c++) begin
      @(negedge clk);
      bus.start = (c == v.restart);
      if (c == 1) chk($sformatf("%s busy_c1", v.name), 32'(bus.busy), 1);
      if (bus.out_valid) begin
        if (first < 0) first = c;
        x = (nval % 2 == 0) ? v.xev : v.xod;
        chk($sformatf("%s data k=%0d", v.name, nval), 32'(bus.out_data), 32'(x));
        chk($sformatf("%s index k=%0d", v.name, nval), 32'(bus.out_index), 32'(nval));
        nval++;
      end
      if (bus.done) begin
        if (dcyc < 0) dcyc = c;
        ndone++;
        chk($sformatf("%s busy_at_done", v.name), 32'(bus.busy), 0);
      end
    end
    chk($sformatf("%s first_valid_cycle", v.name), 32'(first), 32'(PL + 1));
    chk($sformatf("%s valid_count", v.name), 32'(nval), 32'(T));
    chk($sformatf("%s done_cycle", v.name), 32'(dcyc), 32'(PL + T + 1));
    chk($sformatf("%s done_count", v.name), 32'(ndone), 1);
    for (int k = 0; k < T; k++)
      chk($sformatf("%s sum_flat[%0d]", v.name, k), 32'(bus.sum_flat[k*16 +: 16]), 32'((k % 2 == 0) ? v.xev : v.xod));
  endtask

  task automatic run5(input logic mode);
    int nval, dcyc;
    nval = 0; dcyc = -1;
    n_vec++;
    bus5.hC_flat = {T5 * N5{16'h3C00}};
    bus5.mean_mode = mode;
    @(negedge clk) bus5.start = 1;
    for (int c = 1; c <= PL5 + T5 + 6; c++) begin
      @(negedge clk);
      bus5.start = 0;
      if (bus5.out_valid) begin
        chk($sformatf("n5 mode%0d data k=%0d", mode, nval), 32'(bus5.out_data), 32'h4500);
        chk($sformatf("n5 mode%0d index k=%0d", mode, nval), 32'(bus5.out_index), 32'(nval));
        if (nval == 0) chk($sformatf("n5 mode%0d first_cycle", mode), 32'(c), 32'(PL5 + 1));
        nval++;
      end
      if (bus5.done && dcyc < 0) dcyc = c;
    end
    chk($sformatf("n5 mode%0d valid_count", mode), 32'(nval), 32'(T5));
    chk($sformatf("n5 mode%0d done_cycle", mode), 32'(dcyc), 32'(PL5 + T5 + 1));
  endtask

  initial begin
    int nval;
    bus.start = 0; bus.mean_mode = 0; bus.hC_flat = '0;
    bus5.start = 0; bus5.mean_mode = 0; bus5.hC_flat = '0;
    vt[0] = '{"sum_ones",   1'b0, 1'b0, 16'h3C00, 16'h3C00, 16'h5000, 16'h5000, 0};
    vt[1] = '{"mean_ones",  1'b1, 1'b0, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 0};
    vt[2] = '{"mean_flush", 1'b1, 1'b1, 16'h0400, 16'h0400, 16'h0000, 16'h0000, 0};
    vt[3] = '{"mean_inf",   1'b1, 1'b1, 16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00, 0};
    vt[4] = '{"sum_mixed",  1'b0, 1'b0, 16'h3800, 16'hBC00, 16'h4C00, 16'hD000, 0};
    vt[5] = '{"mean_mixed", 1'b1, 1'b0, 16'h3800, 16'hBC00, 16'h3800, 16'hBC00, 0};
    vt[6] = '{"restart",    1'b0, 1'b1, 16'h0400, 16'h8400, 16'h0400, 16'h8400, 3};
    vt[7] = '{"mean_negz",  1'b1, 1'b1, 16'h8400, 16'h8400, 16'h8000, 16'h8000, 0};
    repeat (3) @(negedge clk);
    n_vec++;
    chk("reset busy", 32'(bus.busy), 0);
    chk("reset out_valid", 32'(bus.out_valid), 0);
    chk("reset done", 32'(bus.done), 0);
    chk("reset out_data", 32'(bus.out_data), 0);
    chk("reset out_index", 32'(bus.out_index), 0);
    chk("reset sum_flat", 32'(|bus.sum_flat), 0);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) run(vt[i]);
    run5(1'b0);
    run5(1'b1);
    n_vec++;
    for (int g = 0; g < T * N; g++) bus.hC_flat[g*16 +: 16] = 16'h3C00;
    bus.mean_mode = 0;
    @(negedge clk) bus.start = 1;
    @(negedge clk) bus.start = 0;
    repeat (4) @(negedge clk);
    rst_n = 0;
    #1;
    chk("midrun busy", 32'(bus.busy), 0);
    chk("midrun out_data", 32'(bus.out_data), 0);
    chk("midrun out_index", 32'(bus.out_index), 0);
    chk("midrun sum_flat", 32'(|bus.sum_flat), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    nval = 0;
    for (int c = 0; c < PL + T + 4; c++) begin
      @(negedge clk);
      if (bus.out_valid || bus.done) nval++;
    end
    chk("after_reset stray outputs", 32'(nval), 0);
    run(vt[0]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
